// File: rtl/nastilite_regbank_if.sv
// NASTI-Lite control-bus interface (AW/W/B/AR/R channels, no IDs/bursts).
interface nasti_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;
    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/nastilite_regbank.sv
// NASTI-Lite slave register bank: C_NUM_REGS registers, each read/write
// (configuration) or read-only (status from fabric). AW and W are buffered
// independently, byte strobes honoured, SLVERR on illegal accesses, and a
// one-cycle write pulse per register written.
// Optional feature: define NASTILITE_REGBANK_RDCLR_EN to make read/write
// registers flagged in C_RC_MASK clear on read.
module nastilite_regbank #(
    parameter int unsigned            C_NASTI_ADDR_WIDTH = 8,
    parameter int unsigned            C_NASTI_DATA_WIDTH = 64,   // 32 or 64
    parameter int unsigned            C_NUM_REGS         = 8,
    parameter logic [C_NUM_REGS-1:0]  C_RO_MASK          = '0,
    parameter logic [C_NUM_REGS-1:0]  C_RC_MASK          = '0
) (
    input  logic                                       s_nastilite_clk,
    input  logic                                       s_nastilite_areset,
    nasti_if.slave                                     s_nastilite,
    output logic [C_NUM_REGS*C_NASTI_DATA_WIDTH-1:0]   cfg_regs,
    input  logic [C_NUM_REGS*C_NASTI_DATA_WIDTH-1:0]   status_in,
    output logic [C_NUM_REGS-1:0]                      wr_pulse
);
    localparam int unsigned DW   = C_NASTI_DATA_WIDTH;
    localparam int unsigned NB   = DW / 8;
    localparam int unsigned OFS  = $clog2(NB);
    localparam int unsigned IDXW = C_NASTI_ADDR_WIDTH - OFS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-side buffers and response
    logic                            r_aw_full;
    logic [IDXW-1:0]                 r_aw_idx;
    logic                            r_w_full;
    logic [DW-1:0]                   r_w_data;
    logic [NB-1:0]                   r_w_strb;
    logic                            r_b_valid;
    logic [1:0]                      r_b_resp;
    logic [C_NUM_REGS-1:0]           r_wr_pulse;

    // Read-side response
    logic                            r_r_valid;
    logic [DW-1:0]                   r_r_data;
    logic [1:0]                      r_r_resp;

    // Register file
    logic [C_NUM_REGS-1:0][DW-1:0]   r_regs;

    logic                            w_aw_hs;
    logic                            w_w_hs;
    logic                            w_b_hs;
    logic                            w_ar_hs;
    logic                            w_r_hs;
    logic                            w_commit;
    logic [IDXW-1:0]                 w_ar_idx;
    logic [C_NUM_REGS-1:0]           w_wr_sel;   // one-hot of a legal committed write
    logic                            w_wr_legal;
    logic [C_NUM_REGS-1:0]           w_rd_sel;   // one-hot of a read hitting a r/w register
    logic                            w_rd_hit;   // read index is in range
    logic [DW-1:0]                   w_rd_word;
    logic [C_NUM_REGS-1:0]           w_rd_clr;
    logic                            w_unused;

    assign s_nastilite.aw_ready = !r_aw_full && !r_b_valid;
    assign s_nastilite.w_ready  = !r_w_full  && !r_b_valid;
    assign s_nastilite.b_valid  = r_b_valid;
    assign s_nastilite.b_resp   = r_b_resp;
    assign s_nastilite.ar_ready = !r_r_valid;
    assign s_nastilite.r_valid  = r_r_valid;
    assign s_nastilite.r_data   = r_r_data;
    assign s_nastilite.r_resp   = r_r_resp;

    assign w_aw_hs  = s_nastilite.aw_valid && s_nastilite.aw_ready;
    assign w_w_hs   = s_nastilite.w_valid  && s_nastilite.w_ready;
    assign w_b_hs   = r_b_valid && s_nastilite.b_ready;
    assign w_ar_hs  = s_nastilite.ar_valid && s_nastilite.ar_ready;
    assign w_r_hs   = r_r_valid && s_nastilite.r_ready;
    // Both halves of the write present and no response outstanding
    assign w_commit = r_aw_full && r_w_full && !r_b_valid;
    assign w_ar_idx = s_nastilite.ar_addr[C_NASTI_ADDR_WIDTH-1:OFS];

    assign cfg_regs = r_regs;
    assign wr_pulse = r_wr_pulse;

    // Address decode; an index matching no register is out of range
    always_comb begin
        w_wr_sel  = '0;
        w_rd_sel  = '0;
        w_rd_hit  = 1'b0;
        w_rd_word = '0;
        for (int k = 0; k < int'(C_NUM_REGS); k++) begin
            if (r_aw_idx == IDXW'(k) && !C_RO_MASK[k])
                w_wr_sel[k] = 1'b1;
            if (w_ar_idx == IDXW'(k)) begin
                w_rd_hit    = 1'b1;
                w_rd_sel[k] = !C_RO_MASK[k];
                w_rd_word   = C_RO_MASK[k] ? status_in[k*DW +: DW] : r_regs[k];
            end
        end
    end

    assign w_wr_legal = |w_wr_sel;

`ifdef NASTILITE_REGBANK_RDCLR_EN
    assign w_rd_clr = w_ar_hs ? (w_rd_sel & C_RC_MASK) : '0;
`else
    assign w_rd_clr = '0;
`endif

    // Byte-offset address bits, unread status words and the clear mask
    // (in the default build) are intentionally ignored.
    assign w_unused = &{1'b0, s_nastilite.aw_addr[OFS-1:0],
                        s_nastilite.ar_addr[OFS-1:0], status_in, C_RC_MASK};

    // Write channel: AW/W buffers, commit, B response and write pulse
    always_ff @(posedge s_nastilite_clk) begin
        if (s_nastilite_areset) begin
            r_aw_full  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= s_nastilite.aw_addr[C_NASTI_ADDR_WIDTH-1:OFS];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= s_nastilite.w_data;
                r_w_strb <= s_nastilite.w_strb;
            end
            // Commit cannot coincide with a handshake: ready is low while full
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_b_valid <= 1'b1;
                r_b_resp  <= w_wr_legal ? RESP_OKAY : RESP_SLVERR;
            end else if (w_b_hs) begin
                r_b_valid <= 1'b0;
            end
            r_wr_pulse <= w_commit ? w_wr_sel : '0;
        end
    end

    // Register file: clear-on-read first, strobed write bytes override it
    always_ff @(posedge s_nastilite_clk) begin
        if (s_nastilite_areset) begin
            r_regs <= '0;
        end else begin
            for (int k = 0; k < int'(C_NUM_REGS); k++) begin
                for (int b = 0; b < int'(NB); b++) begin
                    if (w_rd_clr[k])
                        r_regs[k][b*8 +: 8] <= 8'h00;
                    if (w_commit && w_wr_sel[k] && r_w_strb[b])
                        r_regs[k][b*8 +: 8] <= r_w_data[b*8 +: 8];
                end
            end
        end
    end

    // Read channel: capture data at AR handshake, hold until R handshake
    always_ff @(posedge s_nastilite_clk) begin
        if (s_nastilite_areset) begin
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_resp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_r_valid <= 1'b1;
            r_r_data  <= w_rd_word;
            r_r_resp  <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (w_r_hs) begin
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
        end
    end
endmodule

// File: tb/tb_nastilite_regbank.sv
// Self-checking bench for nastilite_regbank (8 regs x 64 bit, reg 7 read-only,
// reg 1 clear-on-read when NASTILITE_REGBANK_RDCLR_EN is defined).
module tb_nastilite_regbank;
    localparam logic [7:0] RO = 8'h80;
    localparam logic [7:0] RC = 8'h02;

    logic         clk = 1'b0;
    logic         areset;
    logic [511:0] status_in;
    logic [511:0] cfg_regs;
    logic [7:0]   wr_pulse;

    int errors = 0;
    int checks = 0;

    logic [63:0] m_regs [8];   // reference register contents

    nasti_if #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) bus ();

    nastilite_regbank #(
        .C_NASTI_ADDR_WIDTH(8), .C_NASTI_DATA_WIDTH(64), .C_NUM_REGS(8),
        .C_RO_MASK(RO), .C_RC_MASK(RC)
    ) dut (
        .s_nastilite_clk(clk), .s_nastilite_areset(areset), .s_nastilite(bus),
        .cfg_regs(cfg_regs), .status_in(status_in), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] data;
        logic [7:0]  strb;
        int          awd;
        int          wd;
        logic [1:0]  resp;
        int          widx;
        logic [63:0] word;
        logic [7:0]  pulse;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a write is legal for an in-range, writable register
    function automatic bit m_legal(input int idx);
        return idx < 8 && !RO[idx];
    endfunction

    task automatic m_write(input int idx, input logic [63:0] d, input logic [7:0] s);
        if (m_legal(idx))
            for (int b = 0; b < 8; b++)
                if (s[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic m_read(input int idx, output logic [63:0] v);
        if (idx >= 8)      v = '0;
        else if (RO[idx])  v = status_in[idx*64 +: 64];
        else begin
            v = m_regs[idx];
`ifdef NASTILITE_REGBANK_RDCLR_EN
            if (RC[idx]) m_regs[idx] = '0;
`endif
        end
    endtask

    task automatic check_regs(input string nm);
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s cfg[%0d]", nm, k), cfg_regs[k*64 +: 64], RO[k] ? 64'h0 : m_regs[k]);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, " b_valid"},  64'(bus.b_valid), 0);
        chk({nm, " b_resp"},   64'(bus.b_resp), 0);
        chk({nm, " r_valid"},  64'(bus.r_valid), 0);
        chk({nm, " r_resp"},   64'(bus.r_resp), 0);
        chk({nm, " r_data"},   bus.r_data, 0);
        chk({nm, " wr_pulse"}, 64'(wr_pulse), 0);
        chk({nm, " aw_ready"}, 64'(bus.aw_ready), 1);
        chk({nm, " w_ready"},  64'(bus.w_ready), 1);
        chk({nm, " ar_ready"}, 64'(bus.ar_ready), 1);
        chk({nm, " cfg_regs"}, 64'(|cfg_regs), 0);
    endtask

    // Full write transaction with independent AW/W start delays; b_ready high.
    task automatic do_write(input logic [7:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int awd, input int wd,
                            input logic [1:0] eresp, input logic [7:0] epulse);
        int cyc = 0, hs_last = -1;
        bit aw_done = 0, w_done = 0, got_b = 0, aw_hs, w_hs;
        bus.b_ready = 1'b1;
        bus.aw_addr = addr;
        bus.w_data  = data;
        bus.w_strb  = strb;
        while (!got_b && cyc < 30) begin
            bus.aw_valid = !aw_done && cyc >= awd;
            bus.w_valid  = !w_done && cyc >= wd;
            aw_hs = bus.aw_valid && bus.aw_ready;
            w_hs  = bus.w_valid && bus.w_ready;
            tick();
            if (aw_hs) begin aw_done = 1; if (cyc > hs_last) hs_last = cyc; end
            if (w_hs)  begin w_done = 1;  if (cyc > hs_last) hs_last = cyc; end
            cyc++;
            if (bus.b_valid) begin
                got_b = 1;
                chk($sformatf("wr %h b latency", addr), 64'(cyc), 64'(hs_last + 2));
                chk($sformatf("wr %h b_resp", addr), 64'(bus.b_resp), 64'(eresp));
                chk($sformatf("wr %h wr_pulse", addr), 64'(wr_pulse), 64'(epulse));
            end
        end
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        if (!got_b) begin
            checks++; errors++;
            $display("FAIL wr %h timeout: no b_valid within %0d cycles", addr, cyc);
        end
        tick();
        chk($sformatf("wr %h b_valid cleared", addr), 64'(bus.b_valid), 0);
        chk($sformatf("wr %h pulse one cycle", addr), 64'(wr_pulse), 0);
        m_write(int'(addr >> 3), data, strb);
    endtask

    // Full read transaction; r_ready held low for 'hold' cycles after r_valid.
    task automatic do_read(input logic [7:0] addr, input int hold, output logic [63:0] got);
        int cyc = 0;
        int idx = int'(addr >> 3);
        logic [63:0] exp;
        m_read(idx, exp);
        bus.ar_addr  = addr;
        bus.ar_valid = 1'b1;
        bus.r_ready  = 1'b0;
        while (!bus.ar_ready && cyc < 20) begin tick(); cyc++; end
        if (!bus.ar_ready) begin
            checks++; errors++;
            $display("FAIL rd %h timeout: ar_ready never high", addr);
        end
        tick();
        bus.ar_valid = 1'b0;
        got = bus.r_data;
        chk($sformatf("rd %h r_valid", addr), 64'(bus.r_valid), 1);
        chk($sformatf("rd %h r_data", addr), bus.r_data, exp);
        chk($sformatf("rd %h r_resp", addr), 64'(bus.r_resp), idx < 8 ? 0 : 2);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk($sformatf("rd %h hold r_valid", addr), 64'(bus.r_valid), 1);
            chk($sformatf("rd %h hold r_data", addr), bus.r_data, exp);
            chk($sformatf("rd %h hold ar_ready", addr), 64'(bus.ar_ready), 0);
        end
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
        chk($sformatf("rd %h r_valid cleared", addr), 64'(bus.r_valid), 0);
        chk($sformatf("rd %h r_data cleared", addr), bus.r_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [63:0] got;

        vecs[0] = '{8'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 2'b00, 2, 64'hDEADBEEF_CAFEF00D, 8'h04};
        vecs[1] = '{8'h18, 64'h11223344_55667788, 8'h0F, 3, 0, 2'b00, 3, 64'h00000000_55667788, 8'h08};
        vecs[2] = '{8'h38, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 0, 0, 2'b10, 7, 64'h0, 8'h00};
        vecs[3] = '{8'h40, 64'h00000000_00001234, 8'hFF, 0, 1, 2'b10, -1, 64'h0, 8'h00};
        vecs[4] = '{8'h13, 64'h00000000_000000AB, 8'h01, 1, 0, 2'b00, 2, 64'hDEADBEEF_CAFEF0AB, 8'h04};
        vecs[5] = '{8'h08, 64'h00000000_00000001, 8'hFF, 0, 0, 2'b00, 1, 64'h1, 8'h02};
        vecs[6] = '{8'h00, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 0, 2, 2'b00, 0, 64'h0, 8'h01};

        for (int k = 0; k < 8; k++) m_regs[k] = '0;
        status_in    = '0;
        bus.aw_valid = 0; bus.aw_addr = 0; bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0;
        bus.b_ready  = 1; bus.ar_valid = 0; bus.ar_addr = 0; bus.r_ready = 0;
        areset = 1'b1;
        repeat (3) tick();
        check_idle("reset");
        areset = 1'b0;
        tick();

        // Directed write vectors
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].awd, vecs[i].wd,
                     vecs[i].resp, vecs[i].pulse);
            if (vecs[i].widx >= 0)
                chk($sformatf("vec%0d word", i), cfg_regs[vecs[i].widx*64 +: 64], vecs[i].word);
            check_regs($sformatf("vec%0d", i));
        end

        // Read-only register returns status, out-of-range read held 5 cycles
        status_in[7*64 +: 64] = 64'hA5;
        do_read(8'h38, 0, got);
        chk("ro read const", got, 64'hA5);
        do_read(8'h40, 5, got);
        chk("oor read const", got, 64'h0);

        // Write commit and read of reg 1 on the same edge (old 1, new 2)
        bus.aw_addr = 8'h08; bus.w_data = 64'h2; bus.w_strb = 8'hFF;
        bus.aw_valid = 1; bus.w_valid = 1; bus.b_ready = 1; bus.r_ready = 0;
        chk("same-edge aw_ready", 64'(bus.aw_ready & bus.w_ready), 1);
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        bus.ar_addr = 8'h08; bus.ar_valid = 1;
        chk("same-edge ar_ready", 64'(bus.ar_ready), 1);
        tick();
        bus.ar_valid = 0;
        m_read(1, got);
        m_write(1, 64'h2, 8'hFF);
        chk("same-edge b_valid", 64'(bus.b_valid), 1);
        chk("same-edge r_valid", 64'(bus.r_valid), 1);
        chk("same-edge r_data model", bus.r_data, got);
        chk("same-edge r_data old", bus.r_data, 64'h1);
        bus.r_ready = 1;
        tick();
        bus.r_ready = 0;
        do_read(8'h08, 0, got);
        chk("after same-edge read", got, 64'h2);
        do_read(8'h08, 0, got);
`ifdef NASTILITE_REGBANK_RDCLR_EN
        chk("second read cleared", got, 64'h0);
`else
        chk("second read kept", got, 64'h2);
`endif
        check_regs("after same-edge");

        // Reset with both responses pending (SLVERR write, SLVERR read)
        bus.aw_addr = 8'h38; bus.w_data = 64'h5; bus.w_strb = 8'hFF;
        bus.aw_valid = 1; bus.w_valid = 1; bus.b_ready = 0;
        bus.ar_addr = 8'h48; bus.ar_valid = 1; bus.r_ready = 0;
        tick();
        bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0;
        tick();
        chk("pend b_valid", 64'(bus.b_valid), 1);
        chk("pend b_resp", 64'(bus.b_resp), 2);
        chk("pend r_resp", 64'(bus.r_resp), 2);
        areset = 1;
        tick();
        areset = 0;
        for (int k = 0; k < 8; k++) m_regs[k] = '0;
        check_idle("reset pending");
        bus.b_ready = 1;

        // Reset with only AW buffered: the later W must pair with a fresh AW
        bus.aw_addr = 8'h10; bus.aw_valid = 1;
        tick();
        bus.aw_valid = 0;
        chk("aw buffered ready low", 64'(bus.aw_ready), 0);
        areset = 1;
        tick();
        areset = 0;
        check_idle("reset aw buffered");
        bus.w_data = 64'h77; bus.w_strb = 8'hFF; bus.w_valid = 1;
        tick();
        bus.w_valid = 0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("dropped aw no b %0d", c), 64'(bus.b_valid), 0);
            tick();
        end
        do_write(8'h20, 64'h77, 8'hFF, 0, 0, 2'b00, 8'h10);
        chk("late aw word4", cfg_regs[4*64 +: 64], 64'h77);
        chk("late aw word2", cfg_regs[2*64 +: 64], 64'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [7:0]  a = 8'($urandom_range(0, 8'h47));
            int          idx = int'(a >> 3);
            if ($urandom_range(0, 1) == 0) begin
                logic [63:0] d = {$urandom, $urandom};
                logic [7:0]  s = 8'($urandom);
                logic [7:0]  p = '0;
                if (m_legal(idx)) p[idx] = 1'b1;
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                         m_legal(idx) ? 2'b00 : 2'b10, p);
                check_regs($sformatf("rand%0d", i));
            end else begin
                status_in[7*64 +: 64] = {$urandom, $urandom};
                do_read(a, $urandom_range(0, 2), got);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nastilite_regbank.md
Name: nastilite_regbank

Overview:
- Parametrised NASTI-Lite slave register bank; successor to the fixed 2-bit configuration frontend.
- Provides C_NUM_REGS data-width registers, each either read/write (configuration) or read-only (status, driven from fabric).
- AW and W are accepted independently in any order; full byte-strobe support; SLVERR on illegal accesses; per-register write pulses.
- Sits between the NASTI-Lite control bus and the memory-controller configuration/status fabric.

Parameters:
- C_NASTI_ADDR_WIDTH, 8: byte address width.
- C_NASTI_DATA_WIDTH, 64: data width; 32 or 64 only.
- C_NUM_REGS, 8: number of registers; 1..2**(C_NASTI_ADDR_WIDTH-OFS), where OFS = log2(C_NASTI_DATA_WIDTH/8).
- C_RO_MASK, 0: bit k set means register k is read-only (reads return status_in word k).
- C_RC_MASK, 0: bit k set means register k is read-to-clear; used only with the optional feature.

Ports:
- s_nastilite_clk  in  1  sole clock.
- s_nastilite_areset  in  1  reset, synchronous, active-high.
- s_nastilite  nasti_if.slave  -  uses aw_valid/ready/addr, w_valid/ready/data/strb, b_valid/ready/resp, ar_valid/ready/addr, r_valid/ready/data/resp.
- cfg_regs  out  C_NUM_REGS*C_NASTI_DATA_WIDTH  current register contents; word k at [k*DW +: DW].
- status_in  in  C_NUM_REGS*C_NASTI_DATA_WIDTH  read-only source; sampled only for registers with C_RO_MASK bit set.
- wr_pulse  out  C_NUM_REGS  one-cycle pulse per register written.

Behaviour:
- Reset, synchronous and honoured at any time: all cfg_regs = 0, wr_pulse = 0, b_valid = r_valid = 0, b_resp = r_resp = 2'b00, r_data = 0, both address/data buffers empty. Any in-flight transaction is dropped with no response.
- Decode: idx = addr[C_NASTI_ADDR_WIDTH-1:OFS]; byte-offset bits are ignored.
- Write path: one-entry AW buffer and one-entry W buffer.
  - aw_ready = !aw_full && !b_valid; w_ready = !w_full && !b_valid. Both are combinational from registered state.
  - A handshake sets the corresponding buffer full.
  - Commit edge: the first edge where both buffers are full and b_valid = 0.
  - On commit, if idx < C_NUM_REGS and C_RO_MASK[idx] = 0: for every byte i in 0..DW/8-1 with strb[i] = 1, register byte i <= data byte i. Then b_resp = OKAY and wr_pulse[idx] = 1 for the next cycle only, even if strb = 0.
  - On commit with an illegal access (idx out of range or read-only): no state change, no pulse, b_resp = SLVERR (2'b10).
  - The commit clears both buffers and sets b_valid.
  - Latency: AW and W both handshaking in cycle t gives b_valid high in cycle t+2.
  - b_valid holds with a stable b_resp until b_ready; it clears on the handshake edge.
- Read path:
  - ar_ready = !r_valid.
  - An AR handshake at cycle t gives r_valid high in cycle t+1, with r_data captured at the handshake edge. Source is status_in word for read-only registers, otherwise the cfg register.
  - Out-of-range read: r_data = 0, r_resp = SLVERR; otherwise OKAY.
  - r_valid and r_data hold until r_ready; on that handshake, r_valid = 0 and r_data = 0.
- Simultaneous read and write commit to the same register on the same edge: the read returns the pre-write value.
- Read and write paths are fully independent; back-to-back writes sustain one write per 3 cycles when b_ready is held high.

Optional Feature:
- Macro NASTILITE_REGBANK_RDCLR_EN.
- Defined: a legal read of a read/write register with C_RC_MASK[idx] = 1 returns the current value and clears that register at the AR handshake edge. If a write commit to the same register lands on the same edge, the write data wins (strobed bytes take the written value; unstrobed bytes clear).
- Undefined: C_RC_MASK is ignored and reads never modify state.

Test Plan:
- Write idx 2 (addr 0x10, DW = 64), data 0xDEADBEEF_CAFEF00D, strb 0xFF, AW and W in the same cycle -> b_valid two cycles later with OKAY; cfg_regs word 2 = 0xDEADBEEF_CAFEF00D; wr_pulse = 8'b0000_0100 for one cycle.
- W issued 3 cycles before AW, strb 0x0F, data 0x11223344_55667788, register previously 0 -> word becomes 0x00000000_55667788; bresp OKAY.
- C_RO_MASK = 8'h80; write idx 7 -> SLVERR, word unchanged, no pulse. Read idx 7 with status_in word 7 = 0xA5 -> r_data 0xA5, OKAY.
- Read addr 0x40 (idx 8, out of range) with r_ready held low for 5 cycles -> r_valid stays high with r_data 0 and SLVERR; ar_ready stays low until the handshake.
- Write commit and read of idx 1 on the same edge, old value 0x1, new value 0x2 -> r_data 0x1; a subsequent read returns 0x2. With NASTILITE_REGBANK_RDCLR_EN and C_RC_MASK[1] = 1, a read of 0x2 returns 0x2 and the next read returns 0.
- Assert reset while AW is buffered and b_valid pending -> next cycle all outputs and registers are 0, and no b_valid is ever returned for the dropped write.
